// File: rtl/shared_pkg.sv
// Shared constants and types for the FIFO and its read-side drain controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package shared_pkg;

   localparam int FIFO_WIDTH = 16;
   localparam int FIFO_DEPTH = 16;

   // Words the drain controller can hold between the FIFO and the consumer.
   localparam int SKID_DEPTH = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } drain_state_e;

endpackage

// File: rtl/fifo_drain_ctrl_skid_buf2.sv
// Two-entry in-order register buffer; head is always the oldest stored word.
// Latency: a pushed word is visible at head one edge after the push.
// Backpressure: a push is dropped when full unless a pop happens in the same cycle.
module skid_buf2 import shared_pkg::*; #(
   parameter int DATA_W = FIFO_WIDTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head,
   output logic [1:0]        occ
);

   logic [DATA_W-1:0] slot0;
   logic [DATA_W-1:0] slot1;
   logic [1:0]        cnt;
   logic              do_pop;
   logic              do_push;

   assign do_pop  = pop && (cnt != 2'd0);
   assign do_push = push && ((cnt < 2'(SKID_DEPTH)) || do_pop);
   assign head    = slot0;
   assign occ     = cnt;

   // Shift toward slot0 on pop; a push lands in the first slot left free.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot0 <= '0;
         slot1 <= '0;
         cnt   <= 2'd0;
      end else begin
         case ({do_push, do_pop})
            2'b10: begin
               if (cnt == 2'd0) slot0 <= push_data;
               else             slot1 <= push_data;
               cnt <= cnt + 2'd1;
            end
            2'b01: begin
               slot0 <= slot1;
               cnt   <= cnt - 2'd1;
            end
            2'b11: begin
               if (cnt == 2'd1) begin
                  slot0 <= push_data;
               end else begin
                  slot0 <= slot1;
                  slot1 <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Pops a synchronous FIFO and presents its words as a valid/ready stream.
// Latency: rd_en sampled at edge N, word captured at N+1, m_valid high after N+1.
// Backpressure: at most two words buffered; no read is issued unless a slot is guaranteed.
module fifo_drain_ctrl import shared_pkg::*; #(
   parameter int DATA_W = FIFO_WIDTH,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              flush,
   input  logic [DATA_W-1:0] fifo_data_out,
   input  logic              fifo_empty,
   input  logic              fifo_underflow,
   output logic              fifo_rd_en,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  beat_count,
   output logic              err_underflow
);

   drain_state_e state;
   drain_state_e state_nxt;
   logic         inflight;
   logic [1:0]   occ;
   logic         pop;
   logic [2:0]   slots_used;
   logic         flush_done;

   assign m_valid = (occ != 2'd0);
   assign pop     = m_valid && m_ready;

   // Words that will occupy the skid after this edge if no new read is issued.
   assign slots_used = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

   assign fifo_rd_en = (state != IDLE) && !fifo_empty && (slots_used < 3'(SKID_DEPTH));
   assign busy       = (state != IDLE) || inflight || (occ != 2'd0);
   assign flush_done = (state == FLUSH) && fifo_empty && !inflight && (occ == 2'd0);

   // Next-state selection; flush outranks enable and is ignored while flushing.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (flush)       state_nxt = FLUSH;
            else if (enable) state_nxt = RUN;
         end
         RUN: begin
            if (flush)        state_nxt = FLUSH;
            else if (!enable) state_nxt = IDLE;
         end
         FLUSH: begin
            if (flush_done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, read tracking, completion pulse, beat counter and sticky error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         inflight      <= 1'b0;
         done          <= 1'b0;
         beat_count    <= '0;
         err_underflow <= 1'b0;
      end else begin
         state    <= state_nxt;
         inflight <= fifo_rd_en;
         done     <= flush_done;
         if (pop) beat_count <= beat_count + CNT_W'(1);
         if (fifo_underflow) err_underflow <= 1'b1;
      end
   end

   // The FIFO's registered read data arrives one cycle after rd_en.
   skid_buf2 #(
      .DATA_W (DATA_W)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight),
      .push_data (fifo_data_out),
      .pop       (pop),
      .head      (m_data),
      .occ       (occ)
   );

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed bench for fifo_drain_ctrl with a behavioural one-cycle-latency FIFO.
// Expected words are queued when written to the FIFO and retired on each handshake.
// Beat counter is modelled modulo 2^CNT_W with CNT_W = 4 to exercise wrap.
module tb_fifo_drain_ctrl;
   import shared_pkg::*;

   localparam int DW = FIFO_WIDTH;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic          flush;
   logic [DW-1:0] fifo_data_out;
   logic          fifo_empty;
   logic          fifo_underflow;
   logic          fifo_rd_en;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;
   logic          busy;
   logic          done;
   logic [CW-1:0] beat_count;
   logic          err_underflow;

   always #5 clk = ~clk;

   fifo_drain_ctrl #(
      .DATA_W (DW),
      .CNT_W  (CW)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .enable         (enable),
      .flush          (flush),
      .fifo_data_out  (fifo_data_out),
      .fifo_empty     (fifo_empty),
      .fifo_underflow (fifo_underflow),
      .fifo_rd_en     (fifo_rd_en),
      .m_data         (m_data),
      .m_valid        (m_valid),
      .m_ready        (m_ready),
      .busy           (busy),
      .done           (done),
      .beat_count     (beat_count),
      .err_underflow  (err_underflow)
   );

   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] exp_q[$];
   int            n_vec = 0;
   int            n_fail = 0;
   int            cyc = 0;
   int            bc_model = 0;
   int            pops = 0;
   int            delivered = 0;
   int            first_rd, first_vld, first_hs, last_hs, hs_n;
   logic          hold_prev = 1'b0;
   logic [DW-1:0] data_prev = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_word(input logic [DW-1:0] w);
      fifo_q.push_back(w);
      exp_q.push_back(w);
      fifo_empty = 1'b0;
   endtask

   task automatic clear_trackers();
      first_rd  = -1;
      first_vld = -1;
      first_hs  = -1;
      last_hs   = -1;
      hs_n      = 0;
   endtask

   // One clock: sample before the edge, then advance the FIFO model after it.
   task automatic step();
      logic          rd_s;
      logic          hs;
      logic [DW-1:0] exp_w;
      #1;
      rd_s = fifo_rd_en;
      hs   = m_valid && m_ready;
      check("rd_while_empty", 32'(fifo_rd_en && fifo_empty), 32'd0);
      if (hold_prev) check("data_hold", 32'(m_data), 32'(data_prev));
      if (rd_s && first_rd < 0) first_rd = cyc;
      if (m_valid && first_vld < 0) first_vld = cyc;
      if (hs) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $error("FAIL extra_beat: observed %0h expected no beat", m_data);
         end else begin
            exp_w = exp_q.pop_front();
            check("beat_data", 32'(m_data), 32'(exp_w));
         end
         delivered++;
         bc_model = (bc_model + 1) % (1 << CW);
         if (first_hs < 0) first_hs = cyc;
         last_hs = cyc;
         hs_n++;
      end
      hold_prev = m_valid && !m_ready;
      data_prev = m_data;
      @(posedge clk);
      #1;
      cyc++;
      if (rd_s && fifo_q.size() != 0) begin
         fifo_data_out = fifo_q.pop_front();
         pops++;
      end
      fifo_empty = (fifo_q.size() == 0);
      check("beat_count", 32'(beat_count), 32'(bc_model));
   endtask

   // Pulse reset mid-run; words already taken from the FIFO are lost.
   task automatic apply_reset();
      rst = 1'b1;
      #1;
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_beat_count", 32'(beat_count), 32'd0);
      check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < pops - delivered; i++) begin
         if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      pops      = 0;
      delivered = 0;
      bc_model  = 0;
      hold_prev = 1'b0;
   endtask

   initial begin
      rst            = 1'b1;
      enable         = 1'b0;
      flush          = 1'b0;
      m_ready        = 1'b0;
      fifo_underflow = 1'b0;
      fifo_data_out  = '0;
      fifo_empty     = 1'b1;
      @(posedge clk);
      #1;
      check("reset_m_valid", 32'(m_valid), 32'd0);
      check("reset_m_data", 32'(m_data), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_beat_count", 32'(beat_count), 32'd0);
      check("reset_err", 32'(err_underflow), 32'd0);

      // Continuous drain of 1..8.
      for (int i = 1; i <= 8; i++) push_word(DW'(i));
      enable  = 1'b1;
      m_ready = 1'b1;
      @(posedge clk);
      #1;
      check("reset_rd_en", 32'(fifo_rd_en), 32'd0);
      rst = 1'b0;
      clear_trackers();
      for (int i = 0; i < 30 && exp_q.size() != 0; i++) step();
      check("t1_drained", 32'(exp_q.size()), 32'd0);
      check("t1_latency", 32'(first_vld - first_rd), 32'd2);
      check("t1_beats", 32'(hs_n), 32'd8);
      check("t1_consecutive", 32'(last_hs - first_hs), 32'd7);
      check("t1_beat_count", 32'(beat_count), 32'd8);
      check("t1_err", 32'(err_underflow), 32'd0);
      enable = 1'b0;
      repeat (3) step();
      check("t1_idle_busy", 32'(busy), 32'd0);

      // Backpressure: stall 5 cycles after the first beat.
      clear_trackers();
      for (int i = 1; i <= 8; i++) push_word(DW'(i));
      enable  = 1'b1;
      m_ready = 1'b1;
      for (int i = 0; i < 20 && hs_n == 0; i++) step();
      check("t2_first_beat", 32'(hs_n), 32'd1);
      m_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check("t2_stall_rd", 32'(fifo_rd_en), 32'd0);
         check("t2_stall_valid", 32'(m_valid), 32'd1);
      end
      check("t2_buffered", 32'(pops - delivered), 32'd2);
      m_ready = 1'b1;
      for (int i = 0; i < 30 && exp_q.size() != 0; i++) step();
      check("t2_drained", 32'(exp_q.size()), 32'd0);
      check("t2_beats", 32'(hs_n), 32'd8);
      check("t2_no_gaps", 32'(last_hs - first_hs), 32'd12);
      enable = 1'b0;
      repeat (3) step();
      check("t2_idle_busy", 32'(busy), 32'd0);

      // Flush with enable low, then a flush on an empty FIFO.
      begin
         int   dn;
         logic busy_at_done;
         dn = 0;
         busy_at_done = 1'b1;
         push_word(DW'(10));
         push_word(DW'(11));
         push_word(DW'(12));
         flush = 1'b1;
         step();
         flush = 1'b0;
         for (int i = 0; i < 20 && dn == 0; i++) begin
            step();
            if (done) begin
               dn++;
               busy_at_done = busy;
            end
         end
         check("t3_done_seen", 32'(dn), 32'd1);
         check("t3_delivered", 32'(exp_q.size()), 32'd0);
         check("t3_busy_fall", 32'(busy_at_done), 32'd0);
         step();
         check("t3_done_single", 32'(done), 32'd0);
         flush = 1'b1;
         step();
         flush = 1'b0;
         check("t3_empty_flush_busy", 32'(busy), 32'd1);
         check("t3_empty_flush_early", 32'(done), 32'd0);
         step();
         check("t3_empty_flush_done", 32'(done), 32'd1);
         step();
      end

      // Reset while the skid is full.
      for (int i = 1; i <= 8; i++) push_word(DW'(i));
      enable  = 1'b1;
      m_ready = 1'b0;
      repeat (4) step();
      check("t4_pre_valid", 32'(m_valid), 32'd1);
      check("t4_pre_held", 32'(pops - delivered), 32'd2);
      apply_reset();
      clear_trackers();
      m_ready = 1'b1;
      for (int i = 0; i < 30 && exp_q.size() != 0; i++) step();
      check("t4_drained", 32'(exp_q.size()), 32'd0);
      check("t4_beats", 32'(hs_n), 32'd6);
      enable = 1'b0;
      repeat (3) step();

      // Sticky underflow error and counter wrap.
      apply_reset();
      check("t5_err_clear", 32'(err_underflow), 32'd0);
      fifo_underflow = 1'b1;
      step();
      fifo_underflow = 1'b0;
      check("t5_err_set", 32'(err_underflow), 32'd1);
      for (int i = 0; i < 17; i++) push_word(DW'(16'h0100 + i));
      enable  = 1'b1;
      m_ready = 1'b1;
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
      check("t5_drained", 32'(exp_q.size()), 32'd0);
      check("t5_wrap", 32'(beat_count), 32'd1);
      check("t5_err_sticky", 32'(err_underflow), 32'd1);
      apply_reset();
      check("t5_err_rst", 32'(err_underflow), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
